// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - multi-cycle execute unit: single-cycle logic/arith/compare, serial shifts
module serial_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] sreg, sreg_shifted, comb_result;
  logic [SHAMT_W-1:0]    cnt, shamt;
  logic [3:0]            op_q;
  logic                  accept, is_shift, go_shift;

  assign shamt    = SrcB[SHAMT_W-1:0];
  assign accept   = start && (state != SHIFT);
  assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
  // A zero-amount shift is just a pass-through, so it takes the single-cycle path.
  assign go_shift = accept && is_shift && (shamt != '0);

  always_comb begin
    comb_result = '0;
    case (Operation)
      OP_AND:  comb_result = SrcA & SrcB;
      OP_XOR:  comb_result = SrcA ^ SrcB;
      OP_ADD:  comb_result = SrcA + SrcB;
      OP_OR:   comb_result = SrcA | SrcB;
      OP_SLL:  comb_result = SrcA << shamt;
      OP_SRL:  comb_result = SrcA >> shamt;
      OP_SUB:  comb_result = SrcA - SrcB;
      OP_SRA:  comb_result = $unsigned($signed(SrcA) >>> shamt);
      OP_EQ:   comb_result = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
      OP_SLT:  comb_result = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_SLTU: comb_result = {{(DATA_WIDTH-1){1'b0}}, SrcA < SrcB};
      default: comb_result = '0;
    endcase
  end

  always_comb begin
    sreg_shifted = sreg;
    case (op_q)
      OP_SLL:  sreg_shifted = {sreg[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  sreg_shifted = {1'b0, sreg[DATA_WIDTH-1:1]};
      OP_SRA:  sreg_shifted = {sreg[DATA_WIDTH-1], sreg[DATA_WIDTH-1:1]};
      default: sreg_shifted = sreg;
    endcase
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nxt = go_shift ? SHIFT : DONE;
        else       state_nxt = IDLE;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ALUResult <= '0;
      Zero      <= 1'b1;
      cnt       <= '0;
      sreg      <= '0;
      op_q      <= '0;
    end else begin
      state <= state_nxt;
      if (go_shift) begin
        sreg <= SrcA;
        op_q <= Operation;
        cnt  <= shamt;
      end else if (accept) begin
        ALUResult <= comb_result;
        Zero      <= (comb_result == '0);
      end else if (state == SHIFT) begin
        sreg <= sreg_shifted;
        cnt  <= cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          ALUResult <= sreg_shifted;
          Zero      <= (sreg_shifted == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - directed vector bench for serial_alu
module tb_serial_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   Operation;
  logic [W-1:0] SrcA, SrcB;
  logic         busy, done;
  logic [W-1:0] ALUResult;
  logic         Zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  serial_alu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .Operation(Operation),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
    .ALUResult(ALUResult), .Zero(Zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done; returns latency and busy-cycle count.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; Operation = op; SrcA = a; SrcB = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bcnt, dcnt;

    vecs.push_back('{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    vecs.push_back('{4'b0110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1});
    vecs.push_back('{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1});
    vecs.push_back('{4'b0001, 32'h00001234, 32'h000000FF, 32'h000012CB, 1});
    vecs.push_back('{4'b0011, 32'hA0000000, 32'h00000005, 32'hA0000005, 1});
    vecs.push_back('{4'b0111, 32'h80000000, 32'h00000004, 32'hF8000000, 5});
    vecs.push_back('{4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 5});
    vecs.push_back('{4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000, 32});
    vecs.push_back('{4'b0100, 32'h0000ABCD, 32'h00000020, 32'h0000ABCD, 1});
    vecs.push_back('{4'b0111, 32'hF0000000, 32'h00000021, 32'hF8000000, 2});
    vecs.push_back('{4'b0111, 32'h7FFFFFFF, 32'h0000001F, 32'h00000000, 32});
    vecs.push_back('{4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
    vecs.push_back('{4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    vecs.push_back('{4'b1000, 32'h00001234, 32'h00001234, 32'h00000001, 1});
    vecs.push_back('{4'b1000, 32'h00001234, 32'h00001235, 32'h00000000, 1});
    vecs.push_back('{4'b1111, 32'h00000005, 32'h00000005, 32'h00000000, 1});
    vecs.push_back('{4'b1011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});

    reset = 1'b1; start = 1'b0; Operation = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", ALUResult, 32'h0);
    check("reset_zero", Zero, 1'b1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("vec%0d_done", i), done, 1'b1);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy", i), bcnt, vecs[i].lat - 1);
      check($sformatf("vec%0d_result", i), ALUResult, vecs[i].exp);
      check($sformatf("vec%0d_zero", i), Zero, vecs[i].exp == 0);
    end

    // done is a single pulse; result holds afterwards
    @(negedge clk);
    check("pulse_done_low", done, 1'b0);
    check("pulse_hold", ALUResult, 32'h0);

    // back-to-back single-cycle ops
    @(negedge clk);
    start = 1'b1; Operation = 4'b0010; SrcA = 32'd10; SrcB = 32'd20;
    @(negedge clk);
    check("b2b_done0", done, 1'b1);
    check("b2b_res0", ALUResult, 32'd30);
    Operation = 4'b0001; SrcA = 32'hFF; SrcB = 32'h0F;
    @(negedge clk);
    check("b2b_done1", done, 1'b1);
    check("b2b_res1", ALUResult, 32'hF0);
    Operation = 4'b1000; SrcA = 32'd7; SrcB = 32'd7;
    @(negedge clk);
    check("b2b_done2", done, 1'b1);
    check("b2b_res2", ALUResult, 32'd1);
    start = 1'b0;
    @(negedge clk);
    check("b2b_done_low", done, 1'b0);
    check("b2b_hold", ALUResult, 32'd1);

    // start pulsed during busy is ignored
    @(negedge clk);
    start = 1'b1; Operation = 4'b0101; SrcA = 32'h80000000; SrcB = 32'd3;
    @(negedge clk);
    lat = 1;
    Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd1;
    @(negedge clk);
    lat = 2;
    start = 1'b0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("ign_done", done, 1'b1);
    check("ign_lat", lat, 4);
    check("ign_result", ALUResult, 32'h10000000);
    @(negedge clk);
    check("ign_done_low", done, 1'b0);
    check("ign_hold", ALUResult, 32'h10000000);

    // reset in the 2nd cycle of a shift by 10
    @(negedge clk);
    start = 1'b1; Operation = 4'b0100; SrcA = 32'h1; SrcB = 32'd10;
    @(negedge clk);
    start = 1'b0;
    check("mid_busy1", busy, 1'b1);
    @(negedge clk);
    check("mid_busy2", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_result", ALUResult, 32'h0);
    check("mid_rst_zero", Zero, 1'b1);
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("mid_no_done", dcnt, 0);
    run_op(4'b0010, 32'd2, 32'd3, lat, bcnt);
    check("post_rst_done", done, 1'b1);
    check("post_rst_lat", lat, 1);
    check("post_rst_result", ALUResult, 32'd5);
    check("post_rst_zero", Zero, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
